// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default data width for the skid stage.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;
  localparam int DATA_W = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  assign count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  assign count = count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: registered valid/ready stage with a two-entry skid buffer, flush and stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  // Handshake outputs come from state only, so in_ready never depends on out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: begin
          state_d = in_fire ? (out_fire ? ONE : TWO) : (out_fire ? EMPTY : ONE);
          main_d  = (in_fire && out_fire) ? in_data : main_q;
          skid_d  = (in_fire && !out_fire) ? in_data : skid_q;
        end
        TWO: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk  (clk),
    .reset(reset),
    .inc  (in_valid & ~in_ready),
    .count(stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed scenarios for pipe_skid_reg, plus a 4-bit-counter copy for saturation.
module tb_pipe_skid_reg;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, flush = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [31:0] out_data, s_out_data;
  logic [15:0] stall_cnt;
  logic [3:0] s_stall_cnt;
  int total = 0, bad = 0, exp_stall = 0;

  pipe_skid_reg dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt));
  pipe_skid_reg #(.CNT_W(4)) u_sat (.clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .flush(flush), .stall_cnt(s_stall_cnt));

  always #5 clk = ~clk;

  task automatic test_reset();
    in_valid = 1; in_data = 32'h12345678; out_ready = 0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    reset = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_first_valid got %b want 1", out_valid); end
    total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL rst_first_data got %h want 12345678", out_data); end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1; in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_data !== i) begin bad++; $display("FAIL stream_out[%0d] got %b/%h want 1/%h", i, out_valid, out_data, i); end
    end
    in_valid = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = 32'h12345678;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_data !== 32'h12345678) begin bad++; $display("FAIL bp_first got %b/%h want 1/12345678", in_ready, out_data); end
    in_data = 32'h87654321;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_data !== 32'h12345678) begin bad++; $display("FAIL bp_full got %b/%h want 0/12345678", in_ready, out_data); end
    in_data = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_stall++;
      total++; if (in_ready !== 1'b0 || stall_cnt !== exp_stall) begin bad++; $display("FAIL bp_stall[%0d] got %b/%0d want 0/%0d", i, in_ready, stall_cnt, exp_stall); end
    end
    out_ready = 1;
    @(negedge clk);
    exp_stall++;
    total++; if (out_data !== 32'h87654321 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got %h/%b want 87654321/1", out_data, in_ready); end
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL bp_release_cnt got %0d want %0d", stall_cnt, exp_stall); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hCAFEF00D) begin bad++; $display("FAIL bp_third got %b/%h want 1/cafef00d", out_valid, out_data); end
    in_valid = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'hA1;
    @(negedge clk);
    in_data = 32'hA2;
    @(negedge clk);
    in_data = 32'hA3; flush = 1;
    @(negedge clk);
    exp_stall++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got %b/%b want 0/1", out_valid, in_ready); end
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL flush_cnt got %0d want %0d", stall_cnt, exp_stall); end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d] got %b want 0", i, out_valid); end
    end
    total++; if (out_data !== 32'hA1) begin bad++; $display("FAIL flush_hold got %h want a1", out_data); end
  endtask

  task automatic test_saturation();
    reset = 1;
    @(negedge clk);
    reset = 0; exp_stall = 0; out_ready = 0; in_valid = 1; in_data = 32'h5;
    repeat (2) @(negedge clk);
    repeat (14) @(negedge clk);
    total++; if (s_stall_cnt !== 4'hE) begin bad++; $display("FAIL sat_14 got %h want e", s_stall_cnt); end
    repeat (6) @(negedge clk);
    total++; if (s_stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_20 got %h want f", s_stall_cnt); end
    total++; if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_wide got %0d want 20", stall_cnt); end
    repeat (3) @(negedge clk);
    total++; if (s_stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got %h want f", s_stall_cnt); end
  endtask

  task automatic test_async_reset();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got %b/%b want 1/0", out_valid, in_ready); end
    #2 reset = 1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_now got %b/%b want 0/1", out_valid, in_ready); end
    total++; if (stall_cnt !== 16'h0 || s_stall_cnt !== 4'h0) begin bad++; $display("FAIL arst_cnt got %0d/%0d want 0/0", stall_cnt, s_stall_cnt); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL arst_data got %h want 0", out_data); end
    @(negedge clk);
    reset = 0; in_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
